// File: rtl/access_enable_upsizer_pkg.sv
//------------------------------------------------------------------------------
// Module : access_enable_upsizer_pkg
// Brief  : Default geometry and lane-count sizing helper for the upsizer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package access_enable_upsizer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_RATIO = 4;

    // The lane count must reach RATIO itself, hence RATIO+1 codes.
    function automatic int lane_count_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/access_enable_upsizer.sv
//------------------------------------------------------------------------------
// Module : access_enable_upsizer
// Brief  : Pops words from an access/enable FIFO read port and packs RATIO of
//          them into one valid/ready beat, with flush for partial beats.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module access_enable_upsizer
    import access_enable_upsizer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int RATIO = DEFAULT_RATIO,
    localparam int LANES_WIDTH = lane_count_width(RATIO)
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     read_enable,
    input  logic [WIDTH-1:0]         read_data,
    input  logic                     read_empty,
    input  logic                     flush,
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic [RATIO*WIDTH-1:0]   output_data,
    output logic [LANES_WIDTH-1:0]   output_lanes
);

    typedef enum logic [0:0] {
        ST_FILLING = 1'b0,
        ST_HOLDING = 1'b1
    } state_t;

    localparam logic [LANES_WIDTH-1:0] C_FULL_COUNT = LANES_WIDTH'(RATIO);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [LANES_WIDTH-1:0]   r_count;
    logic [LANES_WIDTH-1:0]   r_lanes;
    logic [LANES_WIDTH-1:0]   w_lanes_next;
    logic [LANES_WIDTH-1:0]   w_base;
    logic [LANES_WIDTH-1:0]   w_next_count;
    logic [RATIO*WIDTH-1:0]   r_assembly;
    logic [RATIO*WIDTH-1:0]   w_assembly_next;
    logic                     w_transfer;
    logic                     w_pop;

    assign output_valid = (r_state == ST_HOLDING);
    assign w_transfer   = output_valid & output_ready;

    // Pops only while accumulating or when the held beat leaves this cycle,
    // so a stalled beat never has a word written underneath it.
    assign w_pop        = !reset && !read_empty && ((r_state == ST_FILLING) || w_transfer);
    assign read_enable  = w_pop;

    assign output_data  = r_assembly;
    assign output_lanes = r_lanes;

    always_comb begin
        w_base          = w_transfer ? '0 : r_count;
        w_next_count    = w_base + {{(LANES_WIDTH-1){1'b0}}, w_pop};
        w_assembly_next = r_assembly;
        w_state_next    = r_state;
        w_lanes_next    = r_lanes;

        if (w_transfer) begin
            w_assembly_next = '0;
        end

        if (w_pop) begin
            for (int i = 0; i < RATIO; i++) begin
                if (w_base == LANES_WIDTH'(i)) begin
                    w_assembly_next[i*WIDTH +: WIDTH] = read_data;
                end
            end
        end

        // A held beat that is not accepted keeps the state untouched.
        if ((r_state == ST_FILLING) || w_transfer) begin
            if ((w_next_count == C_FULL_COUNT) || (flush && (w_next_count != '0))) begin
                w_state_next = ST_HOLDING;
                w_lanes_next = w_next_count;
            end else begin
                w_state_next = ST_FILLING;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_FILLING;
            r_count    <= '0;
            r_lanes    <= '0;
            r_assembly <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_next_count;
            r_lanes    <= w_lanes_next;
            r_assembly <= w_assembly_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_access_enable_upsizer.sv
//------------------------------------------------------------------------------
// Module : tb_access_enable_upsizer
// Brief  : Scoreboard bench for access_enable_upsizer with a FWFT FIFO model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_access_enable_upsizer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;
    localparam int LW    = 3;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   read_enable;
    logic [WIDTH-1:0]       read_data;
    logic                   read_empty;
    logic                   flush;
    logic                   output_valid;
    logic                   output_ready;
    logic [RATIO*WIDTH-1:0] output_data;
    logic [LW-1:0]          output_lanes;

    logic [WIDTH-1:0]       fifo[$];
    logic [RATIO*WIDTH-1:0] exp_data[$];
    logic [LW-1:0]          exp_lanes[$];
    logic [WIDTH-1:0]       exp_words[$];
    int                     xfer_cycles[$];

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int pops        = 0;
    bit random_mode = 1'b0;

    access_enable_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clock        (clock),
        .reset        (reset),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_empty   (read_empty),
        .flush        (flush),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_lanes (output_lanes)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic refresh();
        read_empty = (fifo.size() == 0);
        read_data  = read_empty ? '0 : fifo[0];
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    task automatic expect_beat(input logic [RATIO*WIDTH-1:0] d, input logic [LW-1:0] l);
        exp_data.push_back(d);
        exp_lanes.push_back(l);
    endtask

    // Inputs are changed 1 unit after an edge; read_enable is sampled just
    // before the next edge and the FIFO model pops after it.
    task automatic step();
        bit pop_now;
        #1;
        check("no_pop_when_empty", {63'd0, read_enable & read_empty}, 64'd0);
        pop_now = read_enable;
        @(posedge clock);
        #1;
        cycle++;
        if (pop_now && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pops++;
        end
        refresh();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_data.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(exp_data.size()), 64'd0);
        step();
    endtask

    // Monitor: a beat accepted at the coming edge is compared here.
    always @(negedge clock) begin
        if (!reset && output_valid && output_ready) begin
            xfer_cycles.push_back(cycle);
            if (random_mode) begin
                check("rand_lanes_nonzero", {63'd0, output_lanes != '0}, 64'd1);
                for (int i = 0; i < RATIO; i++) begin
                    if (i < int'(output_lanes)) begin
                        if (exp_words.size() == 0)
                            check("rand_extra_word", 64'd1, 64'd0);
                        else
                            check("rand_word", 64'(output_data[i*WIDTH +: WIDTH]), 64'(exp_words.pop_front()));
                    end else begin
                        check("rand_pad_zero", 64'(output_data[i*WIDTH +: WIDTH]), 64'd0);
                    end
                end
            end else if (exp_data.size() == 0) begin
                check("unexpected_beat", 64'(output_data), 64'hDEAD_0000_0000_0000);
            end else begin
                check("beat_data", 64'(output_data), 64'(exp_data.pop_front()));
                check("beat_lanes", 64'(output_lanes), 64'(exp_lanes.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, miscompares %0d", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int n;

        reset        = 1'b1;
        flush        = 1'b0;
        output_ready = 1'b1;
        fifo.push_back(8'h11);
        fifo.push_back(8'h22);
        refresh();

        // Reset with a non-empty FIFO
        #1;
        check("reset_read_enable", 64'(read_enable), 64'd0);
        step();
        check("reset_read_enable2", 64'(read_enable), 64'd0);
        check("reset_valid", 64'(output_valid), 64'd0);
        check("reset_data", 64'(output_data), 64'd0);
        check("reset_lanes", 64'(output_lanes), 64'd0);
        step();
        check("reset_fifo_kept", 64'(fifo.size()), 64'd2);
        reset = 1'b0;

        // Full rate
        xfer_cycles.delete();
        pops = 0;
        for (int w = 3; w <= 8; w++) push(8'(w * 8'h11));
        expect_beat(32'h44332211, 3'd4);
        expect_beat(32'h88776655, 3'd4);
        drain(40);
        check("full_rate_pops", 64'(pops), 64'd8);
        if (xfer_cycles.size() >= 2)
            check("full_rate_gap", 64'(xfer_cycles[1] - xfer_cycles[0]), 64'd4);
        else
            check("full_rate_beats", 64'(xfer_cycles.size()), 64'd2);

        // Backpressure
        output_ready = 1'b0;
        pops = 0;
        for (int w = 1; w <= 8; w++) push(8'(w * 8'h11));
        expect_beat(32'h44332211, 3'd4);
        expect_beat(32'h88776655, 3'd4);
        for (int k = 0; k < 10; k++) begin
            step();
            if (k >= 4) begin
                check("bp_valid", 64'(output_valid), 64'd1);
                check("bp_data_stable", 64'(output_data), 64'h44332211);
                check("bp_lanes_stable", 64'(output_lanes), 64'd4);
            end
        end
        check("bp_pops", 64'(pops), 64'd4);
        check("bp_fifo_left", 64'(fifo.size()), 64'd4);
        output_ready = 1'b1;
        drain(40);

        // Flush of a partial beat
        push(8'hA1);
        push(8'hB2);
        expect_beat(32'h0000B2A1, 3'd2);
        step();
        step();
        check("flush_fifo_empty", 64'(fifo.size()), 64'd0);
        check("flush_not_yet_valid", 64'(output_valid), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain(20);

        // Transfer + pop + flush in the same cycle
        output_ready = 1'b0;
        for (int w = 1; w <= 4; w++) push(8'(w * 8'h11));
        expect_beat(32'h44332211, 3'd4);
        expect_beat(32'h000000CC, 3'd1);
        repeat (5) step();
        check("sim_holding", 64'(output_valid), 64'd1);
        push(8'hCC);
        output_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain(20);

        // Flush with nothing buffered
        flush = 1'b1;
        repeat (3) step();
        flush = 1'b0;
        check("empty_flush_no_beat", 64'(output_valid), 64'd0);

        // Random empty / ready / flush over 500 words
        random_mode = 1'b1;
        pushed = 0;
        while (pushed < 500) begin
            if ($urandom_range(2) != 0) begin
                logic [WIDTH-1:0] w;
                w = 8'($urandom);
                push(w);
                exp_words.push_back(w);
                pushed++;
            end
            output_ready = ($urandom_range(3) != 0);
            flush        = ($urandom_range(7) == 0);
            step();
        end
        output_ready = 1'b1;
        flush        = 1'b1;
        n = 0;
        while ((exp_words.size() > 0 || output_valid) && n < 2000) begin
            step();
            n++;
        end
        flush = 1'b0;
        check("rand_all_words_seen", 64'(exp_words.size()), 64'd0);
        check("rand_fifo_drained", 64'(fifo.size()), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
